coherence_bus_scheduler: RTL
============================

Name: coherence_bus_scheduler

Overview:
- Sequences ownership of the shared snooping coherence bus among NumCaches cache controllers.
- Grants one owner at a time, fairly, in round-robin order.
- Holds the grant for the whole bus transaction until the owner signals done.
- Inserts a programmable turnaround gap after each release, and force-revokes the grant if an owner exceeds the hold limit.

Parameters:
- NumCaches, 4, number of requesting cache controllers (2..16).
- MaxHold, 64, maximum cycles one owner may keep the bus before forced release (>=2).
- TurnCycles, 1, idle bus cycles inserted after every release (1..7).

Ports:
- clk  input  1  clock.
- rstN  input  1  asynchronous, active-low reset.
- req  input  NumCaches  level request per cache; held high until granted.
- done  input  NumCaches  one-cycle pulse from the owner ending its transaction.
- grant  output  NumCaches  registered one-hot bus grant; all-zero when no owner.
- ownerId  output  $clog2(NumCaches)  encoded index of the current owner; 0 when no owner.
- busBusy  output  1  high while any grant is asserted.
- timeoutErr  output  1  one-cycle pulse when an owner is force-revoked.
- timeoutId  output  $clog2(NumCaches)  index of the revoked owner; holds until the next timeout.

Behaviour:
- Reset values: grant=0, ownerId=0, busBusy=0, timeoutErr=0, timeoutId=0, state=IDLE, priority pointer=0, hold and turn counters=0.
- Priority pointer ptr:
  - Index with highest priority; the search proceeds ptr, ptr+1, ... NumCaches-1, 0, ... ptr-1.
  - On every release, ptr <= (owner+1) mod NumCaches.
  - ptr is unchanged while IDLE with no requests.
- State IDLE:
  - If req != 0 at edge t, then at t+1: grant = one-hot winner, ownerId = winner, busBusy=1, holdCnt=0, state=BUSY.
  - Otherwise stay IDLE.
  - Grant latency from req rising in IDLE is exactly 1 cycle.
- State BUSY:
  - holdCnt increments each cycle.
  - Normal release: if done[ownerId]=1, then next cycle grant=0, busBusy=0, ptr updated, turnCnt=0, state=TURN.
  - Timeout: else if holdCnt==MaxHold-1, the same release occurs and, in addition, timeoutErr=1 for that one cycle and timeoutId=ownerId.
  - The grant is therefore high for at most MaxHold cycles.
  - done bits from non-owners are ignored.
  - Deassertion of req[owner] while BUSY is ignored; the grant persists until done or timeout.
- State TURN:
  - grant=0.
  - turnCnt increments; at turnCnt==TurnCycles-1, state=IDLE.
  - req is not evaluated during TURN.
  - Minimum spacing between one grant falling and the next rising is therefore TurnCycles+1 cycles.
- Simultaneous events:
  - done[owner] in the same cycle as the timeout threshold counts as a normal release; no timeoutErr.
  - With multiple req bits, only the first in rotating order from ptr wins.
- Invariants:
  - grant is always one-hot or zero.
  - ownerId equals the encoding of grant whenever busBusy=1.
- Reset mid-operation: asserting rstN low in any state immediately clears grant, busBusy and timeoutErr asynchronously; ptr returns to 0.

Test Plan:
- Reset, then req=4'b0100 at cycle 0 -> grant=4'b0100 and ownerId=2 at cycle 1; done[2] at cycle 5 -> grant=0 at cycle 6; IDLE at cycle 7 with TurnCycles=1.
- req=4'b1111 held; each owner pulses done 3 cycles after grant -> grant order 0,1,2,3,0; no owner is granted twice before all others; the gap between grants is 2 cycles.
- Owner 1 granted and never pulses done, MaxHold=64 -> grant[1] is high for exactly 64 cycles, then timeoutErr=1 for 1 cycle with timeoutId=1; the next grant goes to index 2 if requesting.
- While owner 0 is busy, pulse done[3] and drop req[0] -> grant remains 4'b0001; only done[0] releases it.
- done[owner] pulses on exactly the timeout cycle (holdCnt=63) -> normal release, timeoutErr stays 0.
- Assert rstN=0 mid-BUSY with grant=4'b1000 -> grant=0 and busBusy=0 without waiting for a clock edge; after release, req=4'b1001 -> index 0 is granted (ptr=0).

Source files
------------

// File: rtl/coherence_bus_scheduler.sv
// Round-robin owner sequencer for the shared snooping coherence bus.
// Each grant is held until the owner's done pulse or a hold-limit timeout, and is followed by a turnaround gap.
module coherence_bus_scheduler #(
    parameter int NumCaches  = 4,
    parameter int MaxHold    = 64,
    parameter int TurnCycles = 1
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic [NumCaches-1:0]         req,
    input  logic [NumCaches-1:0]         done,
    output logic [NumCaches-1:0]         grant,
    output logic [$clog2(NumCaches)-1:0] ownerId,
    output logic                         busBusy,
    output logic                         timeoutErr,
    output logic [$clog2(NumCaches)-1:0] timeoutId
);

    localparam int IdW   = $clog2(NumCaches);
    localparam int HoldW = $clog2(MaxHold);

    localparam logic [HoldW-1:0]     HoldLast = HoldW'(MaxHold - 1);
    localparam logic [2:0]           TurnLast = 3'(TurnCycles - 1);
    localparam logic [IdW-1:0]       LastId   = IdW'(NumCaches - 1);
    localparam logic [NumCaches-1:0] OneBit   = NumCaches'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t               r_state;
    logic [IdW-1:0]       r_ptr;
    logic [HoldW-1:0]     r_holdCnt;
    logic [2:0]           r_turnCnt;
    logic [NumCaches-1:0] r_grant;
    logic [IdW-1:0]       r_ownerId;
    logic                 r_busBusy;
    logic                 r_timeoutErr;
    logic [IdW-1:0]       r_timeoutId;

    logic                 w_found;
    logic [IdW-1:0]       w_winner;
    logic [IdW:0]         w_sum;
    logic [IdW-1:0]       w_cand;
    logic [IdW-1:0]       w_nextPtr;
    logic                 w_ownerDone;
    logic                 w_holdExpired;

    // Walk the requests backwards from ptr+N-1 down to ptr so the last hit,
    // which is the closest to ptr in rotating order, is the one that sticks.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_cand   = '0;
        for (int i = NumCaches - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (IdW + 1)'(i);
            if (w_sum >= (IdW + 1)'(NumCaches)) begin
                w_cand = IdW'(w_sum - (IdW + 1)'(NumCaches));
            end else begin
                w_cand = IdW'(w_sum);
            end
            if (req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_nextPtr     = (r_ownerId == LastId) ? '0 : r_ownerId + 1'b1;
    assign w_ownerDone   = done[r_ownerId];
    assign w_holdExpired = (r_holdCnt == HoldLast);

    // A done pulse on the threshold cycle wins over the timeout, so the error
    // pulse only fires for an owner that genuinely overstayed.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_holdCnt    <= '0;
            r_turnCnt    <= '0;
            r_grant      <= '0;
            r_ownerId    <= '0;
            r_busBusy    <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_timeoutId  <= '0;
        end else begin
            r_timeoutErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant   <= OneBit << w_winner;
                        r_ownerId <= w_winner;
                        r_busBusy <= 1'b1;
                        r_holdCnt <= '0;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_ownerDone || w_holdExpired) begin
                        r_grant   <= '0;
                        r_ownerId <= '0;
                        r_busBusy <= 1'b0;
                        r_ptr     <= w_nextPtr;
                        r_turnCnt <= '0;
                        r_state   <= TURN;
                        if (!w_ownerDone) begin
                            r_timeoutErr <= 1'b1;
                            r_timeoutId  <= r_ownerId;
                        end
                    end else begin
                        r_holdCnt <= r_holdCnt + 1'b1;
                    end
                end
                TURN: begin
                    if (r_turnCnt == TurnLast) begin
                        r_state <= IDLE;
                    end else begin
                        r_turnCnt <= r_turnCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign ownerId    = r_ownerId;
    assign busBusy    = r_busBusy;
    assign timeoutErr = r_timeoutErr;
    assign timeoutId  = r_timeoutId;

    // Structural invariants of the grant encoding.
    assert property (@(posedge clk) disable iff (!rstN) $onehot0(r_grant));
    assert property (@(posedge clk) disable iff (!rstN) r_busBusy == (r_grant != '0));
    assert property (@(posedge clk) disable iff (!rstN)
                     !r_busBusy || (r_grant == (OneBit << r_ownerId)));

endmodule
